// File: rtl/armleocpu_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module : armleocpu_decode_pkg
// Brief  : Shared encodings for the fetch/decode/execute buses and decode helpers
// Rev    : 1.0  initial release
// ============================================================================
package armleocpu_decode_pkg;

   localparam int E2F_CMD_WIDTH = 2;
   localparam logic [E2F_CMD_WIDTH-1:0] E2F_CMD_NONE         = 2'd0;
   localparam logic [E2F_CMD_WIDTH-1:0] E2F_CMD_START_BRANCH = 2'd1;
   localparam logic [E2F_CMD_WIDTH-1:0] E2F_CMD_FLUSH        = 2'd2;
   localparam logic [E2F_CMD_WIDTH-1:0] E2F_CMD_ABORT        = 2'd3;

   localparam int F2E_TYPE_WIDTH = 1;
   localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INSTR             = 1'b0;
   localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INTERRUPT_PENDING = 1'b1;

   localparam int D2E_CLASS_WIDTH = 4;
   localparam logic [D2E_CLASS_WIDTH-1:0] D2E_CLASS_ALU     = 4'd0;
   localparam logic [D2E_CLASS_WIDTH-1:0] D2E_CLASS_ALUI    = 4'd1;
   localparam logic [D2E_CLASS_WIDTH-1:0] D2E_CLASS_LOAD    = 4'd2;
   localparam logic [D2E_CLASS_WIDTH-1:0] D2E_CLASS_STORE   = 4'd3;
   localparam logic [D2E_CLASS_WIDTH-1:0] D2E_CLASS_BRANCH  = 4'd4;
   localparam logic [D2E_CLASS_WIDTH-1:0] D2E_CLASS_JAL     = 4'd5;
   localparam logic [D2E_CLASS_WIDTH-1:0] D2E_CLASS_JALR    = 4'd6;
   localparam logic [D2E_CLASS_WIDTH-1:0] D2E_CLASS_LUI     = 4'd7;
   localparam logic [D2E_CLASS_WIDTH-1:0] D2E_CLASS_AUIPC   = 4'd8;
   localparam logic [D2E_CLASS_WIDTH-1:0] D2E_CLASS_SYSTEM  = 4'd9;
   localparam logic [D2E_CLASS_WIDTH-1:0] D2E_CLASS_FENCE   = 4'd10;
   localparam logic [D2E_CLASS_WIDTH-1:0] D2E_CLASS_FENCEI  = 4'd11;
   localparam logic [D2E_CLASS_WIDTH-1:0] D2E_CLASS_ILLEGAL = 4'd12;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_SERIAL = 1'b1
   } state_t;

   typedef struct packed {
      logic [F2E_TYPE_WIDTH-1:0] typ;
      logic [31:0]               instr;
      logic [31:0]               pc;
   } f2d_entry_t;

   function automatic logic [D2E_CLASS_WIDTH-1:0] classify(input logic [31:0] instr);
      logic [D2E_CLASS_WIDTH-1:0] cls;
      cls = D2E_CLASS_ILLEGAL;
      if (instr[1:0] == 2'b11) begin
         case (instr[6:0])
            7'b0110011: cls = D2E_CLASS_ALU;
            7'b0010011: cls = D2E_CLASS_ALUI;
            7'b0000011: cls = D2E_CLASS_LOAD;
            7'b0100011: cls = D2E_CLASS_STORE;
            7'b1100011: cls = D2E_CLASS_BRANCH;
            7'b1101111: cls = D2E_CLASS_JAL;
            7'b1100111: cls = (instr[14:12] == 3'b000) ? D2E_CLASS_JALR : D2E_CLASS_ILLEGAL;
            7'b0110111: cls = D2E_CLASS_LUI;
            7'b0010111: cls = D2E_CLASS_AUIPC;
            7'b1110011: cls = D2E_CLASS_SYSTEM;
            7'b0001111: begin
               if (instr[14:12] == 3'b000)
                  cls = D2E_CLASS_FENCE;
               else if (instr[14:12] == 3'b001)
                  cls = D2E_CLASS_FENCEI;
               else
                  cls = D2E_CLASS_ILLEGAL;
            end
            default:    cls = D2E_CLASS_ILLEGAL;
         endcase
      end
      return cls;
   endfunction

   // CSR instructions source rs1, so SYSTEM counts as an rs1 user
   function automatic logic uses_rs1(input logic [D2E_CLASS_WIDTH-1:0] cls);
      return (cls == D2E_CLASS_ALU)   || (cls == D2E_CLASS_ALUI)   ||
             (cls == D2E_CLASS_LOAD)  || (cls == D2E_CLASS_STORE)  ||
             (cls == D2E_CLASS_BRANCH)|| (cls == D2E_CLASS_JALR)   ||
             (cls == D2E_CLASS_SYSTEM);
   endfunction

   function automatic logic uses_rs2(input logic [D2E_CLASS_WIDTH-1:0] cls);
      return (cls == D2E_CLASS_ALU) || (cls == D2E_CLASS_STORE) || (cls == D2E_CLASS_BRANCH);
   endfunction

endpackage
`default_nettype wire

// File: rtl/armleocpu_decode_skid.sv
`default_nettype none
// ============================================================================
// Module : armleocpu_decode_skid
// Brief  : Two-entry FIFO absorbing fetch results while decode is stalled
// Rev    : 1.0  initial release
// ============================================================================
module armleocpu_decode_skid
   import armleocpu_decode_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  f2d_entry_t push_entry,
   input  logic       pop,
   output f2d_entry_t head,
   output logic [1:0] count
);

   f2d_entry_t r_mem [0:1];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (push)
            r_wr_ptr <= ~r_wr_ptr;
         if (pop)
            r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush)
         r_mem[r_wr_ptr] <= push_entry;
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;

`ifdef FORMAL_RULES
   // Fetch keeps at most one request in flight once ABORT is raised
   always @(posedge clk) begin
      if (rst_n && !flush) begin
         assert (!(push && !pop && r_count == 2'd2));
         assert (!(pop && r_count == 2'd0));
      end
   end
`endif

endmodule
`default_nettype wire

// File: rtl/armleocpu_decode.sv
`default_nettype none
// ============================================================================
// Module : armleocpu_decode
// Brief  : Decode stage: buffers fetch output, classifies, throttles fetch
// Rev    : 1.0  initial release
// ============================================================================
module armleocpu_decode
   import armleocpu_decode_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,

   input  logic                       f2d_valid,
   input  logic [F2E_TYPE_WIDTH-1:0]  f2d_type,
   input  logic [31:0]                f2d_instr,
   input  logic [31:0]                f2d_pc,

   output logic                       d2f_ready,
   output logic [E2F_CMD_WIDTH-1:0]   d2f_cmd,
   output logic [31:0]                d2f_branchtarget,

   output logic                       rs1_read,
   output logic [4:0]                 rs1_addr,
   output logic                       rs2_read,
   output logic [4:0]                 rs2_addr,

   output logic                       d2e_valid,
   output logic [F2E_TYPE_WIDTH-1:0]  d2e_type,
   output logic [31:0]                d2e_instr,
   output logic [31:0]                d2e_pc,
   output logic [D2E_CLASS_WIDTH-1:0] d2e_class,

   input  logic                       e2d_ready,
   input  logic [E2F_CMD_WIDTH-1:0]   e2d_cmd,
   input  logic [31:0]                e2d_branchtarget
);

   state_t                     r_state;
   logic [1:0]                 w_count;
   f2d_entry_t                 w_head;
   f2d_entry_t                 w_f2d_entry;
   f2d_entry_t                 w_load_entry;
   logic                       w_redirect;
   logic                       w_d2e_free;
   logic                       w_accept;
   logic                       w_load;
   logic                       w_push;
   logic                       w_pop;
   logic                       w_load_is_instr;
   logic                       w_load_serial;
   logic [D2E_CLASS_WIDTH-1:0] w_load_class;

   assign w_redirect  = (e2d_cmd != E2F_CMD_NONE);
   assign w_f2d_entry = '{typ: f2d_type, instr: f2d_instr, pc: f2d_pc};
   assign w_d2e_free  = !d2e_valid || e2d_ready;
   assign w_accept    = f2d_valid && !w_redirect && (r_state == ST_RUN);

   // Buffered items go first; an empty FIFO lets fetch bypass straight into D2E
   assign w_load       = !w_redirect && (r_state == ST_RUN) && w_d2e_free &&
                         ((w_count != 2'd0) || w_accept);
   assign w_load_entry = (w_count != 2'd0) ? w_head : w_f2d_entry;
   assign w_pop        = w_load && (w_count != 2'd0);
   assign w_push       = w_accept && !(w_load && (w_count == 2'd0));

   assign w_load_class    = classify(w_load_entry.instr);
   assign w_load_is_instr = (w_load_entry.typ == F2E_TYPE_INSTR);
   assign w_load_serial   = !w_load_is_instr ||
                            (w_load_class == D2E_CLASS_SYSTEM) ||
                            (w_load_class == D2E_CLASS_FENCEI);

   armleocpu_decode_skid u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (w_redirect),
      .push       (w_push),
      .push_entry (w_f2d_entry),
      .pop        (w_pop),
      .head       (w_head),
      .count      (w_count)
   );

   always_comb begin
      d2f_cmd          = E2F_CMD_NONE;
      d2f_branchtarget = e2d_branchtarget;
      if (w_redirect)
         d2f_cmd = e2d_cmd;
      else if (r_state == ST_SERIAL)
         d2f_cmd = E2F_CMD_ABORT;
      else if ((w_count != 2'd0) || (d2e_valid && !e2d_ready))
         d2f_cmd = E2F_CMD_ABORT;
   end

   assign d2f_ready = (d2f_cmd != E2F_CMD_NONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_RUN;
         d2e_valid <= 1'b0;
         d2e_type  <= F2E_TYPE_INSTR;
         d2e_instr <= 32'd0;
         d2e_pc    <= 32'd0;
         d2e_class <= D2E_CLASS_ILLEGAL;
         rs1_read  <= 1'b0;
         rs2_read  <= 1'b0;
         rs1_addr  <= 5'd0;
         rs2_addr  <= 5'd0;
      end else begin
         rs1_read <= 1'b0;
         rs2_read <= 1'b0;
         if (w_redirect) begin
            d2e_valid <= 1'b0;
            r_state   <= ST_RUN;
         end else if (w_load) begin
            d2e_valid <= 1'b1;
            d2e_type  <= w_load_entry.typ;
            d2e_instr <= w_load_entry.instr;
            d2e_pc    <= w_load_entry.pc;
            d2e_class <= w_load_class;
            rs1_read  <= w_load_is_instr && uses_rs1(w_load_class);
            rs2_read  <= w_load_is_instr && uses_rs2(w_load_class);
            rs1_addr  <= w_load_entry.instr[19:15];
            rs2_addr  <= w_load_entry.instr[24:20];
            if (w_load_serial)
               r_state <= ST_SERIAL;
         end else if (e2d_ready) begin
            d2e_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_armleocpu_decode.sv
`default_nettype none
// ============================================================================
// Module : tb_armleocpu_decode
// Brief  : Directed self-checking bench for the decode stage
// Rev    : 1.0  initial release
// ============================================================================
module tb_armleocpu_decode;
   import armleocpu_decode_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        f2d_valid;
   logic [F2E_TYPE_WIDTH-1:0] f2d_type;
   logic [31:0] f2d_instr;
   logic [31:0] f2d_pc;
   logic        d2f_ready;
   logic [E2F_CMD_WIDTH-1:0] d2f_cmd;
   logic [31:0] d2f_branchtarget;
   logic        rs1_read;
   logic [4:0]  rs1_addr;
   logic        rs2_read;
   logic [4:0]  rs2_addr;
   logic        d2e_valid;
   logic [F2E_TYPE_WIDTH-1:0] d2e_type;
   logic [31:0] d2e_instr;
   logic [31:0] d2e_pc;
   logic [D2E_CLASS_WIDTH-1:0] d2e_class;
   logic        e2d_ready;
   logic [E2F_CMD_WIDTH-1:0] e2d_cmd;
   logic [31:0] e2d_branchtarget;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   armleocpu_decode dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .f2d_valid        (f2d_valid),
      .f2d_type         (f2d_type),
      .f2d_instr        (f2d_instr),
      .f2d_pc           (f2d_pc),
      .d2f_ready        (d2f_ready),
      .d2f_cmd          (d2f_cmd),
      .d2f_branchtarget (d2f_branchtarget),
      .rs1_read         (rs1_read),
      .rs1_addr         (rs1_addr),
      .rs2_read         (rs2_read),
      .rs2_addr         (rs2_addr),
      .d2e_valid        (d2e_valid),
      .d2e_type         (d2e_type),
      .d2e_instr        (d2e_instr),
      .d2e_pc           (d2e_pc),
      .d2e_class        (d2e_class),
      .e2d_ready        (e2d_ready),
      .e2d_cmd          (e2d_cmd),
      .e2d_branchtarget (e2d_branchtarget)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
      f2d_valid = 1'b1;
      f2d_type  = F2E_TYPE_INSTR;
      f2d_instr = instr;
      f2d_pc    = pc;
   endtask

   task automatic fetch_idle();
      f2d_valid = 1'b0;
      f2d_instr = 32'd0;
      f2d_pc    = 32'd0;
   endtask

   initial begin
      rst_n            = 1'b0;
      f2d_valid        = 1'b0;
      f2d_type         = F2E_TYPE_INSTR;
      f2d_instr        = 32'd0;
      f2d_pc           = 32'd0;
      e2d_ready        = 1'b1;
      e2d_cmd          = E2F_CMD_NONE;
      e2d_branchtarget = 32'd0;

      // Reset state
      tick(); tick();
      chk("rst_d2e_valid", {31'd0, d2e_valid}, 32'd0);
      chk("rst_d2f_ready", {31'd0, d2f_ready}, 32'd0);
      chk("rst_d2f_cmd",   {30'd0, d2f_cmd}, {30'd0, E2F_CMD_NONE});
      chk("rst_rs1_read",  {31'd0, rs1_read}, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: ADDI x1,x0,5 passes through with one cycle latency
      fetch(32'h00500093, 32'h2000);
      #1 chk("t1_d2f_cmd", {30'd0, d2f_cmd}, {30'd0, E2F_CMD_NONE});
      tick();
      fetch_idle();
      chk("t1_d2e_valid", {31'd0, d2e_valid}, 32'd1);
      chk("t1_class",     {28'd0, d2e_class}, {28'd0, D2E_CLASS_ALUI});
      chk("t1_pc",        d2e_pc, 32'h2000);
      chk("t1_rs1_read",  {31'd0, rs1_read}, 32'd1);
      chk("t1_rs1_addr",  {27'd0, rs1_addr}, 32'd0);
      chk("t1_rs2_read",  {31'd0, rs2_read}, 32'd0);

      // 2: execute stalls, two fetches buffered, then drained in order
      e2d_ready = 1'b0;
      fetch(32'h00208133, 32'h2004);
      #1 chk("t2_abort_stall", {30'd0, d2f_cmd}, {30'd0, E2F_CMD_ABORT});
      tick();
      fetch(32'h00412023, 32'h2008);
      tick();
      fetch_idle();
      chk("t2_count2",     {30'd0, dut.w_count}, 32'd2);
      chk("t2_hold_pc",    d2e_pc, 32'h2000);
      chk("t2_hold_valid", {31'd0, d2e_valid}, 32'd1);
      #1 chk("t2_abort_fifo", {30'd0, d2f_cmd}, {30'd0, E2F_CMD_ABORT});
      chk("t2_ready_fifo", {31'd0, d2f_ready}, 32'd1);
      e2d_ready = 1'b1;
      tick();
      chk("t2_pc_a",    d2e_pc, 32'h2004);
      chk("t2_class_a", {28'd0, d2e_class}, {28'd0, D2E_CLASS_ALU});
      chk("t2_rs1_a",   {26'd0, rs1_read, rs1_addr}, {26'd0, 1'b1, 5'd1});
      chk("t2_rs2_a",   {26'd0, rs2_read, rs2_addr}, {26'd0, 1'b1, 5'd2});
      tick();
      chk("t2_pc_b",    d2e_pc, 32'h2008);
      chk("t2_class_b", {28'd0, d2e_class}, {28'd0, D2E_CLASS_STORE});
      chk("t2_rs1_b",   {26'd0, rs1_read, rs1_addr}, {26'd0, 1'b1, 5'd2});
      chk("t2_rs2_b",   {26'd0, rs2_read, rs2_addr}, {26'd0, 1'b1, 5'd4});
      tick();
      chk("t2_drained", {31'd0, d2e_valid}, 32'd0);
      chk("t2_count0",  {30'd0, dut.w_count}, 32'd0);

      // 3: MRET serialises; following fetch is dropped until a branch redirect
      fetch(32'h30200073, 32'h200C);
      tick();
      chk("t3_class",  {28'd0, d2e_class}, {28'd0, D2E_CLASS_SYSTEM});
      chk("t3_state",  {31'd0, dut.r_state}, {31'd0, ST_SERIAL});
      fetch(32'h00500093, 32'h2010);
      #1 chk("t3_abort_serial", {30'd0, d2f_cmd}, {30'd0, E2F_CMD_ABORT});
      tick();
      fetch_idle();
      chk("t3_dropped_valid", {31'd0, d2e_valid}, 32'd0);
      chk("t3_dropped_count", {30'd0, dut.w_count}, 32'd0);
      tick();
      chk("t3_abort_again", {30'd0, d2f_cmd}, {30'd0, E2F_CMD_ABORT});
      e2d_cmd          = E2F_CMD_START_BRANCH;
      e2d_branchtarget = 32'h1000;
      #1 chk("t3_fwd_cmd",   {30'd0, d2f_cmd}, {30'd0, E2F_CMD_START_BRANCH});
      chk("t3_fwd_target", d2f_branchtarget, 32'h1000);
      chk("t3_fwd_ready",  {31'd0, d2f_ready}, 32'd1);
      tick();
      e2d_cmd = E2F_CMD_NONE;
      chk("t3_state_run", {31'd0, dut.r_state}, {31'd0, ST_RUN});
      #1 chk("t3_cmd_none", {30'd0, d2f_cmd}, {30'd0, E2F_CMD_NONE});

      // 4: FENCE.I behind a stalled instruction, leftover entry flushed by FLUSH
      e2d_ready = 1'b0;
      fetch(32'h00500093, 32'h1000);
      tick();
      fetch(32'h0000100F, 32'h1004);
      tick();
      fetch(32'h00500093, 32'h1008);
      tick();
      fetch_idle();
      e2d_ready = 1'b1;
      tick();
      chk("t4_class",  {28'd0, d2e_class}, {28'd0, D2E_CLASS_FENCEI});
      chk("t4_pc",     d2e_pc, 32'h1004);
      chk("t4_state",  {31'd0, dut.r_state}, {31'd0, ST_SERIAL});
      tick();
      chk("t4_held_count", {30'd0, dut.w_count}, 32'd1);
      chk("t4_no_issue",   {31'd0, d2e_valid}, 32'd0);
      e2d_cmd = E2F_CMD_FLUSH;
      #1 chk("t4_fwd_flush", {30'd0, d2f_cmd}, {30'd0, E2F_CMD_FLUSH});
      tick();
      e2d_cmd = E2F_CMD_NONE;
      chk("t4_flushed", {30'd0, dut.w_count}, 32'd0);
      chk("t4_valid0",  {31'd0, d2e_valid}, 32'd0);

      // 5: redirect with full FIFO and a coincident fetch drops everything
      e2d_ready = 1'b0;
      fetch(32'h00500093, 32'h3000);
      tick();
      fetch(32'h00500093, 32'h3004);
      tick();
      fetch(32'h00500093, 32'h3008);
      tick();
      chk("t5_full", {30'd0, dut.w_count}, 32'd2);
      fetch(32'h00500093, 32'h300C);
      e2d_cmd          = E2F_CMD_START_BRANCH;
      e2d_branchtarget = 32'h4000;
      #1 chk("t5_fwd_target", d2f_branchtarget, 32'h4000);
      tick();
      fetch_idle();
      e2d_cmd = E2F_CMD_NONE;
      chk("t5_valid0", {31'd0, d2e_valid}, 32'd0);
      chk("t5_count0", {30'd0, dut.w_count}, 32'd0);
      e2d_ready = 1'b1;
      tick();
      chk("t5_still_empty", {31'd0, d2e_valid}, 32'd0);

      // 6: asynchronous reset while serialising with a buffered entry
      e2d_ready = 1'b0;
      fetch(32'h00500093, 32'h5000);
      tick();
      fetch(32'h30200073, 32'h5004);
      tick();
      fetch(32'h00500093, 32'h5008);
      tick();
      fetch_idle();
      e2d_ready = 1'b1;
      tick();
      e2d_ready = 1'b0;
      chk("t6_serial",  {31'd0, dut.r_state}, {31'd0, ST_SERIAL});
      chk("t6_count1",  {30'd0, dut.w_count}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", {31'd0, d2e_valid}, 32'd0);
      chk("t6_rst_ready", {31'd0, d2f_ready}, 32'd0);
      chk("t6_rst_count", {30'd0, dut.w_count}, 32'd0);
      chk("t6_rst_state", {31'd0, dut.r_state}, {31'd0, ST_RUN});
      tick(); tick();
      rst_n     = 1'b1;
      e2d_ready = 1'b1;
      fetch(32'h00500093, 32'h6000);
      tick();
      fetch(32'h00004501, 32'h6004);
      chk("t6_after_pc",    d2e_pc, 32'h6000);
      chk("t6_after_class", {28'd0, d2e_class}, {28'd0, D2E_CLASS_ALUI});
      tick();
      fetch_idle();
      chk("t6_illegal",     {28'd0, d2e_class}, {28'd0, D2E_CLASS_ILLEGAL});
      chk("t6_illegal_rs",  {30'd0, rs1_read, rs2_read}, 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
